// File: rtl/serial_ripple_adder.sv
// Bit-serial adder: one full-adder cell (two half adders plus an OR) and a
// registered carry produce the sum LSB first, framed by a start/busy/done handshake.
module serial_ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aShift_q, bShift_q;
  logic [WIDTH-2:0] partSum_q, partSum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, busy_q, done_q;

  logic ha1Sum, ha1Carry, ha2Sum, ha2Carry;

  assign ha1Sum   = aShift_q[0] ^ bShift_q[0];
  assign ha1Carry = aShift_q[0] & bShift_q[0];
  assign ha2Sum   = ha1Sum ^ carry_q;
  assign ha2Carry = ha1Sum & carry_q;
  assign carry_d  = ha1Carry | ha2Carry;

  // Partial sum holds the WIDTH-1 earlier bits; the current bit completes the word.
  always_comb begin
    partSum_d = '0;
    for (int i = 0; i < WIDTH - 2; i++) begin
      partSum_d[i] = partSum_q[i+1];
    end
    partSum_d[WIDTH-2] = ha2Sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aShift_q  <= '0;
      bShift_q  <= '0;
      partSum_q <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            aShift_q <= a;
            bShift_q <= b;
            carry_q  <= cin;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ADD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ADD: begin
          aShift_q  <= aShift_q >> 1;
          bShift_q  <= bShift_q >> 1;
          partSum_q <= partSum_d;
          carry_q   <= carry_d;
          count_q   <= count_q + CW'(1);
          if (count_q == LAST_BIT) begin
            sum_q   <= {ha2Sum, partSum_q};
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_ripple_adder.md
# serial_ripple_adder

Bit-serial adder that takes two WIDTH-bit operands and a carry-in, then produces the sum one bit per clock, LSB first. Each bit is formed by a single full-adder cell, built from two half adders and an OR on their carries, plus a registered carry. It sits directly upstream of the result consumers in the arithmetic datapath and trades latency for minimal adder area. A start/busy/done handshake frames each operation, and the result registers hold the last sum until the next completion.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge only.
- b  input  WIDTH  operand B; captured on the accepting edge only.
- cin  input  1  carry-in; captured on the accepting edge only.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  registered result of a+b+cin mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

## Operation
- States: IDLE, ADD, DONE. Encoding is free.
- Reset (rst_n=0): state=IDLE. busy=0, done=0, sum=0, cout=0. Internal shift registers, carry and bit counter are all 0. Reset is effective immediately and asynchronously, including mid-operation. An aborted operation produces no done and leaves sum=0.
- IDLE or DONE with start=1:
  - Load the A/B shift registers from a and b.
  - Load carry register from cin.
  - Set counter=0.
  - Go to ADD.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- ADD, each cycle:
  - s = A[0]^B[0]^c. Realise this as half adder (A[0],B[0]) followed by half adder (that sum, c).
  - Next carry = carry1 | carry2.
  - Shift A and B right by one.
  - Shift s into the MSB of the partial-sum shift register.
  - Increment counter.
- ADD, at the update where counter reaches WIDTH-1:
  - Copy the completed partial sum (including this cycle's bit) to sum.
  - Copy the final carry to cout.
  - Go to DONE.
- start is ignored while in ADD. Operand inputs are don't-care except on the accepting edge.
- sum and cout change only at completion or reset. They are never visible mid-operation.
- Arithmetic: {cout,sum} = a + b + cin, evaluated at WIDTH+1 bits.
- Counter width: $clog2(WIDTH)+1 bits. No wrap-around within an operation.

## Timing
- Let E0 be the rising edge that accepts start.
- busy=1 in the cycles following E0 through E(WIDTH); it drops after E(WIDTH).
- done=1 for exactly one cycle, after edge E(WIDTH). sum and cout are valid in that same cycle.
- Latency from the accepting edge to done is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge. busy then rises in the next cycle with no IDLE gap. done is still exactly one cycle wide.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset values: hold rst_n=0, then release -> busy=0, done=0, sum=0x00, cout=0 (WIDTH=8).
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulsed at E0.
  - busy is high for 8 cycles.
  - done is high exactly in the cycle after E8.
  - sum=0x96, cout=0.
- Carry chain, WIDTH=8:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Ignore start while busy: start held high during ADD with different operands -> first result is unaffected, and no extra done pulse fires during ADD. With start still high in the DONE cycle, the new operands are accepted.
- Reset mid-operation: assert rst_n=0 at cycle 4 of ADD -> state is IDLE, outputs are 0 immediately, and no done pulse is produced. A fresh start afterwards gives the correct result.
- Back-to-back: issue start in the DONE cycle of a 0x01+0x02 add -> first result sum=0x03. The second operation 0x80+0x80 gives sum=0x00, cout=1, with its done exactly 9 cycles after the first done.
